// File: rtl/memory_tester_pkg.sv
// Shared types for the memory self-test master.
package memory_tester_pkg;

  typedef enum logic [1:0] {
    ModeConst   = 2'd0,
    ModeAddr    = 2'd1,
    ModeChecker = 2'd2
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StReadReq,
    StReadResp,
    StDone
  } state_e;

  // Raw mode encoding 3 is folded onto CONST.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return ModeAddr;
      2'd2:    return ModeChecker;
      default: return ModeConst;
    endcase
  endfunction

endpackage

// File: rtl/Memory.sv
// Request/response memory bus shared by masters and slaves.
interface Memory #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_address;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_write;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output m_address, m_data, m_valid, m_write, s_ready,
    input  m_ready, s_data, s_valid
  );

  modport slave (
    input  m_address, m_data, m_valid, m_write, s_ready,
    output m_ready, s_data, s_valid
  );
endinterface

// File: rtl/memory_tester_pattern.sv
// Expected-data generator, shared by the write-data and compare paths.
module memory_tester_pattern
  import memory_tester_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           IDX_WIDTH  = 5,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(32'hAAAA_AAAA)
) (
  input  mode_e                 mode_i,
  input  logic [IDX_WIDTH-1:0]  index_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic odd;
  assign odd = (index_i & IDX_WIDTH'(1)) != '0;

  // Select the data word for this beat.
  always_comb begin
    data_o = PATTERN;
    case (mode_i)
      ModeAddr:    data_o = DATA_WIDTH'(addr_i);
      ModeChecker: data_o = odd ? ~PATTERN : PATTERN;
      default:     data_o = PATTERN;
    endcase
  end

endmodule

// File: rtl/memory_tester.sv
// Memory self-test master: write sweep, then read-back-and-compare sweep.
module memory_tester
  import memory_tester_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter logic [ADDR_WIDTH-1:0] STRIDE     = ADDR_WIDTH'(4),
  parameter int unsigned           COUNT      = 16,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = DATA_WIDTH'(32'hAAAA_AAAA),
  parameter int unsigned           ERR_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  Memory.master                 memory,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_WIDTH-1:0]  error_count,
  output logic [ADDR_WIDTH-1:0] first_fail
);

  localparam int unsigned          IdxWidth = $clog2(COUNT + 1);
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(COUNT - 1);

  state_e                  state_q, state_d;
  mode_e                   mode_q, mode_d;
  logic [IdxWidth-1:0]     idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ERR_WIDTH-1:0]    err_q, err_d;
  logic [ADDR_WIDTH-1:0]   ff_q, ff_d;
  logic [DATA_WIDTH-1:0]   exp_data;
  logic                    last_beat;

  memory_tester_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IdxWidth),
    .PATTERN    (PATTERN)
  ) u_pattern (
    .mode_i  (mode_q),
    .index_i (idx_q),
    .addr_i  (addr_q),
    .data_o  (exp_data)
  );

  assign last_beat = (idx_q == LastIdx);

  // Sequencer next-state and bus drive.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    idx_d            = idx_q;
    addr_d           = addr_q;
    err_d            = err_q;
    ff_d             = ff_q;
    memory.m_valid   = 1'b0;
    memory.m_write   = 1'b0;
    memory.m_address = '0;
    memory.m_data    = '0;
    memory.s_ready   = 1'b0;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StWrite;
          mode_d  = decode_mode(mode);
          idx_d   = '0;
          addr_d  = BASE;
          err_d   = '0;
          ff_d    = '0;
        end
      end
      StWrite: begin
        memory.m_valid   = 1'b1;
        memory.m_write   = 1'b1;
        memory.m_address = addr_q;
        memory.m_data    = exp_data;
        if (memory.m_ready) begin
          if (last_beat) begin
            state_d = StReadReq;
            idx_d   = '0;
            addr_d  = BASE;
          end else begin
            idx_d  = idx_q + IdxWidth'(1);
            addr_d = addr_q + STRIDE;
          end
        end
      end
      StReadReq: begin
        memory.m_valid   = 1'b1;
        memory.m_address = addr_q;
        if (memory.m_ready) begin
          state_d = StReadResp;
        end
      end
      StReadResp: begin
        memory.s_ready = 1'b1;
        if (memory.s_valid) begin
          if (memory.s_data != exp_data) begin
            if (err_q != '1) begin
              err_d = err_q + ERR_WIDTH'(1);
            end
            // A zero count means no earlier mismatch in this run.
            if (err_q == '0) begin
              ff_d = addr_q;
            end
          end
          if (last_beat) begin
            state_d = StDone;
          end else begin
            state_d = StReadReq;
            idx_d   = idx_q + IdxWidth'(1);
            addr_d  = addr_q + STRIDE;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle;
      mode_q  <= ModeConst;
      idx_q   <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // Status outputs decoded from the registered state.
  always_comb begin
    busy        = (state_q == StWrite) || (state_q == StReadReq) || (state_q == StReadResp);
    done        = (state_q == StDone);
    pass        = done && (err_q == '0);
    error_count = err_q;
    first_fail  = ff_q;
  end

endmodule

// File: tb/tb_memory_tester.sv
// Directed bench for memory_tester: two instances (base 0x100 and a wrapping base).
module tb_memory_tester;

  logic        clock;
  logic        reset;
  logic [1:0]  start_s;
  logic [1:0]  mode_s [2];
  logic [1:0]  ready_s;
  logic [1:0]  stall_en;
  logic [1:0]  spur_en;
  logic [1:0]  corrupt_en;
  logic [31:0] corrupt_addr;

  logic [1:0]  busy_s, done_s, pass_s, mv_s, mw_s, sr_s;
  logic [15:0] err_s [2];
  logic [31:0] ff_s  [2];
  logic [31:0] ma_s  [2];
  logic [31:0] md_s  [2];

  int n_checks = 0;
  int n_fails  = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [31:0] Base = (g == 0) ? 32'h0000_0100 : 32'hFFFF_FFF8;

    Memory #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

    logic [31:0] mem [16];
    logic [31:0] wlog_addr [64];
    logic [31:0] wlog_data [64];
    int          wcnt = 0;
    logic        pending;
    logic [31:0] rdata;
    int          delay;

    memory_tester #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .BASE       (Base),
      .STRIDE     (32'd4),
      .COUNT      (4),
      .PATTERN    (32'hAAAA_AAAA),
      .ERR_WIDTH  (16)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start_s[g]),
      .mode        (mode_s[g]),
      .memory      (mem_if),
      .busy        (busy_s[g]),
      .done        (done_s[g]),
      .pass        (pass_s[g]),
      .error_count (err_s[g]),
      .first_fail  (ff_s[g])
    );

    assign mem_if.m_ready = ready_s[g];
    assign mem_if.s_valid = (pending && delay == 0) ||
                            (spur_en[g] && mem_if.m_valid && mem_if.m_write);
    assign mem_if.s_data  = pending ? rdata : 32'hDEAD_BEEF;
    assign mv_s[g] = mem_if.m_valid;
    assign mw_s[g] = mem_if.m_write;
    assign sr_s[g] = mem_if.s_ready;
    assign ma_s[g] = mem_if.m_address;
    assign md_s[g] = mem_if.m_data;

    // Slave model: one outstanding read, optional response delay and corruption.
    always @(posedge clock) begin
      if (!reset) begin
        pending <= 1'b0;
        delay   <= 0;
      end else begin
        if (pending && delay == 0 && mem_if.s_ready) pending <= 1'b0;
        else if (pending && delay > 0) delay <= delay - 1;
        if (mem_if.m_valid && mem_if.m_ready) begin
          if (mem_if.m_write) begin
            mem[mem_if.m_address[5:2]] <= mem_if.m_data;
            wlog_addr[wcnt[5:0]]       <= mem_if.m_address;
            wlog_data[wcnt[5:0]]       <= mem_if.m_data;
            wcnt                       <= wcnt + 1;
          end else begin
            pending <= 1'b1;
            rdata   <= (corrupt_en[g] && mem_if.m_address == corrupt_addr) ? 32'h0
                       : mem[mem_if.m_address[5:2]];
            delay   <= stall_en[g] ? int'($urandom_range(0, 3)) : 0;
          end
        end
      end
    end
  end

  task automatic start_dut(input int g, input logic [1:0] md);
    @(negedge clock);
    start_s[g] = 1'b1;
    mode_s[g]  = md;
    @(posedge clock);
    @(negedge clock);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, output int cyc);
    cyc = 0;
    while (!done_s[g] && cyc < 400) begin
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (busy_s[0] !== 1'b0) begin n_fails++; $display("FAIL reset_busy got %b want 0", busy_s[0]); end
    n_checks++; if (done_s[0] !== 1'b0) begin n_fails++; $display("FAIL reset_done got %b want 0", done_s[0]); end
    n_checks++; if (pass_s[0] !== 1'b0) begin n_fails++; $display("FAIL reset_pass got %b want 0", pass_s[0]); end
    n_checks++; if (mv_s[0] !== 1'b0 || mw_s[0] !== 1'b0 || sr_s[0] !== 1'b0) begin
      n_fails++; $display("FAIL reset_handshake got v%b w%b r%b want 000", mv_s[0], mw_s[0], sr_s[0]);
    end
    n_checks++; if (ma_s[0] !== 32'h0 || md_s[0] !== 32'h0) begin
      n_fails++; $display("FAIL reset_bus got a=%h d=%h want 0", ma_s[0], md_s[0]);
    end
    n_checks++; if (err_s[0] !== 16'h0 || ff_s[0] !== 32'h0) begin
      n_fails++; $display("FAIL reset_results got e=%h f=%h want 0", err_s[0], ff_s[0]);
    end
    reset = 1'b1;
  endtask

  task automatic test_const;
    int cyc;
    int base;
    logic [5:0] ix;
    logic [31:0] ea;
    base = g_dut[0].wcnt;
    start_dut(0, 2'd0);
    n_checks++; if (mv_s[0] !== 1'b1 || mw_s[0] !== 1'b1 || ma_s[0] !== 32'h100 || busy_s[0] !== 1'b1) begin
      n_fails++; $display("FAIL const_first_beat got v%b w%b a=%h busy%b want 1 1 00000100 1",
                          mv_s[0], mw_s[0], ma_s[0], busy_s[0]);
    end
    wait_done(0, cyc);
    n_checks++; if (cyc !== 12) begin n_fails++; $display("FAIL const_latency got %0d want 12", cyc); end
    n_checks++; if (pass_s[0] !== 1'b1 || err_s[0] !== 16'h0 || busy_s[0] !== 1'b0) begin
      n_fails++; $display("FAIL const_result got pass%b err=%h busy%b want 1 0 0", pass_s[0], err_s[0], busy_s[0]);
    end
    for (int k = 0; k < 4; k++) begin
      ix = 6'(base + k);
      ea = 32'h100 + 32'(4 * k);
      n_checks++;
      if (g_dut[0].wlog_addr[ix] !== ea || g_dut[0].wlog_data[ix] !== 32'hAAAA_AAAA) begin
        n_fails++; $display("FAIL const_write%0d got a=%h d=%h want a=%h d=aaaaaaaa", k,
                            g_dut[0].wlog_addr[ix], g_dut[0].wlog_data[ix], ea);
      end
    end
  endtask

  task automatic test_checker;
    int cyc;
    int base;
    logic [5:0] ix;
    base = g_dut[0].wcnt;
    corrupt_en[0] = 1'b1;
    corrupt_addr  = 32'h108;
    start_dut(0, 2'd2);
    wait_done(0, cyc);
    ix = 6'(base + 1);
    n_checks++; if (g_dut[0].wlog_data[ix] !== 32'h5555_5555) begin
      n_fails++; $display("FAIL checker_odd_data got %h want 55555555", g_dut[0].wlog_data[ix]);
    end
    n_checks++; if (err_s[0] !== 16'd1) begin n_fails++; $display("FAIL checker_err got %0d want 1", err_s[0]); end
    n_checks++; if (ff_s[0] !== 32'h108) begin n_fails++; $display("FAIL checker_first_fail got %h want 108", ff_s[0]); end
    n_checks++; if (pass_s[0] !== 1'b0 || done_s[0] !== 1'b1) begin
      n_fails++; $display("FAIL checker_pass got pass%b done%b want 0 1", pass_s[0], done_s[0]);
    end
  endtask

  task automatic test_rerun_after_fail;
    int cyc;
    corrupt_en[0] = 1'b0;
    start_dut(0, 2'd2);
    n_checks++; if (err_s[0] !== 16'h0 || ff_s[0] !== 32'h0) begin
      n_fails++; $display("FAIL rerun_clear got e=%h f=%h want 0", err_s[0], ff_s[0]);
    end
    n_checks++; if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b1) begin
      n_fails++; $display("FAIL rerun_status got done%b busy%b want 0 1", done_s[0], busy_s[0]);
    end
    wait_done(0, cyc);
    n_checks++; if (pass_s[0] !== 1'b1 || cyc !== 12) begin
      n_fails++; $display("FAIL rerun_pass got pass%b cyc=%0d want 1 12", pass_s[0], cyc);
    end
  endtask

  task automatic test_wrap;
    int cyc;
    int base;
    logic [5:0] ix;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    base = g_dut[1].wcnt;
    start_dut(1, 2'd1);
    wait_done(1, cyc);
    for (int k = 0; k < 4; k++) begin
      ix = 6'(base + k);
      n_checks++;
      if (g_dut[1].wlog_addr[ix] !== exp_a[k] || g_dut[1].wlog_data[ix] !== exp_a[k]) begin
        n_fails++; $display("FAIL wrap_write%0d got a=%h d=%h want %h", k,
                            g_dut[1].wlog_addr[ix], g_dut[1].wlog_data[ix], exp_a[k]);
      end
    end
    n_checks++; if (pass_s[1] !== 1'b1 || err_s[1] !== 16'h0) begin
      n_fails++; $display("FAIL wrap_pass got pass%b err=%h want 1 0", pass_s[1], err_s[1]);
    end
  endtask

  task automatic test_stalls;
    int cyc;
    logic prev_st;
    logic [31:0] p_addr, p_data;
    stall_en[0] = 1'b1;
    spur_en[0]  = 1'b1;
    start_dut(0, 2'd1);
    prev_st = 1'b0;
    p_addr  = '0;
    p_data  = '0;
    cyc     = 0;
    while (!done_s[0] && cyc < 400) begin
      if (prev_st) begin
        n_checks++;
        if (mv_s[0] !== 1'b1 || ma_s[0] !== p_addr || md_s[0] !== p_data) begin
          n_fails++; $display("FAIL stall_hold got v%b a=%h d=%h want 1 a=%h d=%h",
                              mv_s[0], ma_s[0], md_s[0], p_addr, p_data);
        end
      end
      ready_s[0] = 1'($urandom_range(0, 1));
      prev_st = mv_s[0] && !ready_s[0];
      p_addr  = ma_s[0];
      p_data  = md_s[0];
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    ready_s[0]  = 1'b1;
    stall_en[0] = 1'b0;
    spur_en[0]  = 1'b0;
    n_checks++; if (done_s[0] !== 1'b1) begin n_fails++; $display("FAIL stall_timeout got done%b want 1", done_s[0]); end
    n_checks++; if (pass_s[0] !== 1'b1 || err_s[0] !== 16'h0) begin
      n_fails++; $display("FAIL stall_pass got pass%b err=%h want 1 0", pass_s[0], err_s[0]);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    int rd;
    start_dut(0, 2'd0);
    rd  = 0;
    cyc = 0;
    while (cyc < 50) begin
      if (mv_s[0] && !mw_s[0]) rd++;
      if (rd == 2) break;
      @(posedge clock);
      cyc++;
      @(negedge clock);
    end
    n_checks++; if (rd !== 2) begin n_fails++; $display("FAIL midrun_reach got %0d reads want 2", rd); end
    reset      = 1'b0;
    ready_s[0] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    n_checks++; if (mv_s[0] !== 1'b0 || mw_s[0] !== 1'b0 || sr_s[0] !== 1'b0) begin
      n_fails++; $display("FAIL midrun_handshake got v%b w%b r%b want 000", mv_s[0], mw_s[0], sr_s[0]);
    end
    n_checks++; if (busy_s[0] !== 1'b0 || done_s[0] !== 1'b0 || pass_s[0] !== 1'b0) begin
      n_fails++; $display("FAIL midrun_status got b%b d%b p%b want 000", busy_s[0], done_s[0], pass_s[0]);
    end
    n_checks++; if (ma_s[0] !== 32'h0 || md_s[0] !== 32'h0 || err_s[0] !== 16'h0 || ff_s[0] !== 32'h0) begin
      n_fails++; $display("FAIL midrun_values got a=%h d=%h e=%h f=%h want 0", ma_s[0], md_s[0], err_s[0], ff_s[0]);
    end
    reset      = 1'b1;
    ready_s[0] = 1'b1;
    start_dut(0, 2'd0);
    wait_done(0, cyc);
    n_checks++; if (pass_s[0] !== 1'b1 || cyc !== 12) begin
      n_fails++; $display("FAIL midrun_rerun got pass%b cyc=%0d want 1 12", pass_s[0], cyc);
    end
  endtask

  initial begin
    reset        = 1'b0;
    start_s      = '0;
    mode_s[0]    = 2'd0;
    mode_s[1]    = 2'd0;
    ready_s      = 2'b11;
    stall_en     = '0;
    spur_en      = '0;
    corrupt_en   = '0;
    corrupt_addr = '0;
    test_reset();
    test_const();
    test_checker();
    test_rerun_after_fail();
    test_wrap();
    test_stalls();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/memory_tester.md
# memory_tester

Parametrised memory self-test master that drives the shared `Memory` interface through a write sweep followed by a read-back-and-compare sweep over a configurable address window. It is the next generation of the single-write bring-up stimulus in the core. It adds a programmable base, stride and depth, three data-pattern modes, full valid/ready handshaking on both request and response, and error reporting. It sits in place of, or beside, the processor core as the `Memory.master` during bring-up and memory-subsystem verification.

## Interface
Parameters:
- `ADDR_WIDTH`, 32: request address width; must match the `Memory` interface.
- `DATA_WIDTH`, 32: data width; must match the `Memory` interface.
- `BASE`, 0: first address of the sweep.
- `STRIDE`, 4: address increment between beats.
- `COUNT`, 16: beats per sweep; must be ≥1.
- `PATTERN`, 32'hAAAA_AAAA: seed data for CONST and CHECKER modes.
- `ERR_WIDTH`, 16: width of the error counter.

Ports:
- `clock`  in  1  sole clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  launches a run when sampled high in IDLE or DONE.
- `mode`  in  2  pattern select, sampled on start: 0 CONST, 1 ADDR, 2 CHECKER, 3 treated as CONST.
- `memory`  `Memory.master`  —  drives m_address, m_data, m_valid, m_write, s_ready; samples m_ready, s_data, s_valid.
- `busy`  out  1  high from the start-accept cycle until DONE.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when error_count == 0.
- `error_count`  out  ERR_WIDTH  count of mismatched reads; saturates at all-ones.
- `first_fail`  out  ADDR_WIDTH  address of the first mismatch; 0 if none.

## Operation
- States: IDLE → WRITE → READ_REQ ⇄ READ_RESP → DONE. DONE → WRITE on start.
- Beat address for index i: BASE + i·STRIDE, modulo 2^ADDR_WIDTH. Wrap-around is legal and not flagged.
- Expected data for index i:
  - CONST: PATTERN.
  - ADDR: beat address, zero-extended or truncated to DATA_WIDTH.
  - CHECKER: PATTERN for even i, ~PATTERN for odd i.
- Start:
  - Latch `mode` and clear index, error_count and first_fail.
  - start is ignored in WRITE, READ_REQ and READ_RESP.
- WRITE:
  - Drive m_valid=1 and m_write=1, with address and data for index i.
  - A beat is accepted on m_valid && m_ready; the index then increments.
  - After the last beat, go to READ_REQ with the index cleared.
  - Writes produce no response.
- READ_REQ:
  - Drive m_valid=1, m_write=0, beat address, and m_data=0.
  - s_ready=0 in this state.
  - On accept, go to READ_RESP.
- READ_RESP:
  - Drive m_valid=0 and s_ready=1.
  - On s_valid && s_ready, compare s_data with expected.
  - On mismatch: error_count += 1 (saturating); on the first mismatch of the run, first_fail = beat address.
  - Then go to READ_REQ for the next index, or to DONE after the last index.
- Only one read is outstanding at a time.
- s_valid in any state other than READ_RESP is ignored (s_ready=0).
- DONE: m_valid=0, s_ready=0; results are held until the next start.

## Timing
- Reset values (reset low at a posedge):
  - state IDLE.
  - m_valid, m_write, s_ready, busy, done, pass = 0.
  - m_address, m_data, error_count, first_fail = 0.
- Reset mid-run: the same values apply at the next edge, and m_valid drops even if the beat was not accepted.
- start high at edge N: m_valid is high from cycle N+1.
- m_valid is held with stable address and data until accepted. No retraction.
- Back-to-back writes: the next beat is presented in the cycle after acceptance, so throughput is 1 beat/cycle with m_ready held high.
- Read latency: request accepted at edge N; s_ready high from N+1; the response may arrive at N+1 or later.
- Minimum read cycle is 2 clocks per beat.
- error_count, first_fail and the DONE transition all update at the edge where the last response is accepted. pass is valid the cycle done rises.
- A full run with zero-wait memory takes COUNT + 2·COUNT cycles after start.

## Structure
- Package `memory_tester_pkg` holds:
  - `mode_e` (CONST, ADDR, CHECKER).
  - `state_e` (IDLE, WRITE, READ_REQ, READ_RESP, DONE).
- Index counter width: $clog2(COUNT+1).
- Sub-module `memory_tester_pattern`: combinational; takes (mode, index, address) and produces the expected data. It is shared by the write-data and compare paths.

## Test plan
- COUNT=4, BASE=0x100, STRIDE=4, mode CONST, zero-wait memory model:
  - Writes 0xAAAAAAAA to 0x100, 0x104, 0x108, 0x10C.
  - Reads back; done=1, pass=1, error_count=0, 12 cycles after start.
- Mode CHECKER, with the model corrupting address 0x108 (returns 0):
  - error_count=1, first_fail=0x108, pass=0.
- Mode ADDR, BASE=0xFFFF_FFF8, STRIDE=4, COUNT=4:
  - Addresses are 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 with data equal to address.
  - pass=1.
- Random m_ready and s_valid stalls, plus spurious s_valid during WRITE:
  - m_address and m_data stay stable while stalled.
  - Spurious responses are ignored; pass=1.
- Reset driven low during the second read beat:
  - Next cycle all outputs are at reset values with m_valid=0.
  - A subsequent start completes a clean run.
- start pulsed again in DONE after a failing run:
  - error_count and first_fail are cleared.
  - A clean rerun gives pass=1.
